// File: rtl/systolic_ctrl_pkg.sv
// Shared types and phase-length helpers for the systolic array controller.
package systolic_ctrl_pkg;

    // Controller phases: zero the accumulators, stream operands, read rows out, signal completion.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // One cycle per accumulator row.
    function automatic int clear_len(input int dim);
        return dim;
    endfunction

    // DIM operand columns plus 2*DIM-2 cycles to flush the diagonal skew.
    function automatic int feed_len(input int dim);
        return 3 * dim - 2;
    endfunction

    // One cycle per result row.
    function automatic int drain_len(input int dim);
        return dim;
    endfunction

    // Phase lengths for the default 8x8 array.
    localparam int DEFAULT_DIM = 8;
    localparam int CLEAR_LEN   = clear_len(DEFAULT_DIM);
    localparam int FEED_LEN    = feed_len(DEFAULT_DIM);
    localparam int DRAIN_LEN   = drain_len(DEFAULT_DIM);

endpackage

// File: rtl/systolic_ctrl.sv
// Sequencer for a DIM x DIM systolic matrix-multiply array: clear, feed, drain, done.
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int DIM   = 8,
    parameter int CNT_W = $clog2(3 * DIM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic                   arr_en,
    output logic                   arr_wren,
    output logic [$clog2(DIM)-1:0] arr_crow,
    output logic                   cin_zero,
    output logic                   feed_valid,
    output logic [$clog2(DIM)-1:0] feed_k,
    output logic                   rd_valid,
    output logic [$clog2(DIM)-1:0] rd_row
);

    localparam int IDX_W = $clog2(DIM);

    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(clear_len(DIM) - 1);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(feed_len(DIM) - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(drain_len(DIM) - 1);
    localparam logic [CNT_W-1:0] DIM_CNT    = CNT_W'(DIM);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [IDX_W-1:0] cnt_idx;

    assign cnt_idx = cnt_reg[IDX_W-1:0];

    // State and phase counter registers; reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: counter restarts at zero on every phase change; stall only matters in FEED.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                if (cnt_reg == CLEAR_LAST) begin
                    state_next = FEED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            FEED: begin
                if (!stall) begin
                    if (cnt_reg == FEED_LAST) begin
                        state_next = DRAIN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (cnt_reg == DRAIN_LAST) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode from state and counter only; stall gates the FEED strobes directly.
    always_comb begin
        busy       = (state_reg != IDLE);
        done       = 1'b0;
        arr_en     = 1'b0;
        arr_wren   = 1'b0;
        arr_crow   = '0;
        cin_zero   = 1'b0;
        feed_valid = 1'b0;
        feed_k     = '0;
        rd_valid   = 1'b0;
        rd_row     = '0;
        case (state_reg)
            CLEAR: begin
                arr_wren = 1'b1;
                cin_zero = 1'b1;
                arr_crow = cnt_idx;
            end
            FEED: begin
                arr_en = !stall;
                if (cnt_reg < DIM_CNT) begin
                    feed_valid = !stall;
                    feed_k     = cnt_idx;
                end
            end
            DRAIN: begin
                arr_crow = cnt_idx;
                rd_row   = cnt_idx;
                rd_valid = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: per-run expectations queued at start, consumed as strobes appear.
module tb_systolic_ctrl;

    localparam int DIM   = 8;
    localparam int IDX_W = $clog2(DIM);
    localparam int FLEN  = 3 * DIM - 2;
    localparam int LAT   = DIM + (3 * DIM - 2) + DIM + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stall = 1'b0;
    logic             busy;
    logic             done;
    logic             arr_en;
    logic             arr_wren;
    logic [IDX_W-1:0] arr_crow;
    logic             cin_zero;
    logic             feed_valid;
    logic [IDX_W-1:0] feed_k;
    logic             rd_valid;
    logic [IDX_W-1:0] rd_row;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    bit mon_en = 1'b0;

    int exp_wren_q[$];
    int exp_feed_q[$];
    int exp_rd_q[$];
    int exp_done_q[$];

    systolic_ctrl #(.DIM(DIM)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .arr_en     (arr_en),
        .arr_wren   (arr_wren),
        .arr_crow   (arr_crow),
        .cin_zero   (cin_zero),
        .feed_valid (feed_valid),
        .feed_k     (feed_k),
        .rd_valid   (rd_valid),
        .rd_row     (rd_row)
    );

    always #5 clk = ~clk;

    // Cycle index: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: consume queued expectations as the DUT produces strobes.
    always @(negedge clk) begin
        if (mon_en) begin
            int s;
            s = int'(arr_en) + int'(arr_wren) + int'(rd_valid);
            chk("excl", 32'(s <= 1), 1);
            if (arr_en) en_cnt++;
            if (arr_wren) begin
                if (exp_wren_q.size() == 0) chk("wren_extra", 1, 0);
                else begin
                    chk("clr_crow", arr_crow, exp_wren_q.pop_front());
                    chk("clr_cin0", cin_zero, 1);
                end
            end
            if (feed_valid) begin
                if (exp_feed_q.size() == 0) chk("feed_extra", 1, 0);
                else chk("feed_k", feed_k, exp_feed_q.pop_front());
            end
            if (rd_valid) begin
                if (exp_rd_q.size() == 0) chk("rd_extra", 1, 0);
                else begin
                    int r;
                    r = exp_rd_q.pop_front();
                    chk("rd_row", rd_row, r);
                    chk("rd_crow", arr_crow, r);
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) chk("done_extra", 1, 0);
                else chk("done_cyc", cyc, exp_done_q.pop_front());
            end
        end
    end

    task automatic push_run(input int e, input int stall_len, input int rows, input bit with_done);
        for (int i = 0; i < DIM; i++) exp_wren_q.push_back(i);
        for (int i = 0; i < DIM; i++) exp_feed_q.push_back(i);
        for (int i = 0; i < rows; i++) exp_rd_q.push_back(i);
        if (with_done) exp_done_q.push_back(e + LAT - 1 + stall_len);
    endtask

    // Pulse start for one edge; e returns the cycle index of the edge that sampled it.
    task automatic do_start(output int e);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = cyc;
    endtask

    task automatic finish_run(input string name, input int exp_en);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_idle"}, busy, 0);
        chk({name, "_wren_left"}, exp_wren_q.size(), 0);
        chk({name, "_feed_left"}, exp_feed_q.size(), 0);
        chk({name, "_rd_left"}, exp_rd_q.size(), 0);
        chk({name, "_done_left"}, exp_done_q.size(), 0);
        chk({name, "_en_cnt"}, en_cnt, exp_en);
        $display("run %s complete at cyc %0d, errors so far %0d", name, cyc, errors);
        en_cnt = 0;
        exp_wren_q.delete();
        exp_feed_q.delete();
        exp_rd_q.delete();
        exp_done_q.delete();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_en"}, arr_en, 0);
        chk({name, "_wren"}, arr_wren, 0);
        chk({name, "_crow"}, arr_crow, 0);
        chk({name, "_cin0"}, cin_zero, 0);
        chk({name, "_fv"}, feed_valid, 0);
        chk({name, "_fk"}, feed_k, 0);
        chk({name, "_rdv"}, rd_valid, 0);
        chk({name, "_rdrow"}, rd_row, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        mon_en = 1'b1;

        // Plain run
        do_start(e);
        push_run(e, 0, DIM, 1);
        $display("start basic at cyc %0d", e);
        finish_run("basic", FLEN);

        // Five-cycle stall at feed column 3
        do_start(e);
        push_run(e, 5, DIM, 1);
        $display("start stall5 at cyc %0d", e);
        repeat (DIM + 3) begin
            @(posedge clk); #1;
        end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_k", feed_k, 3);
            chk("stall_en", arr_en, 0);
            chk("stall_fv", feed_valid, 0);
            chk("stall_busy", busy, 1);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        finish_run("stall5", FLEN);

        // Stall during CLEAR and DRAIN has no effect on timing
        do_start(e);
        push_run(e, 0, DIM, 1);
        $display("start stall_ignored at cyc %0d", e);
        stall = 1'b1;
        repeat (DIM) begin
            @(posedge clk); #1;
        end
        stall = 1'b0;
        repeat (FLEN) begin
            @(posedge clk); #1;
        end
        stall = 1'b1;
        finish_run("stall_ignored", FLEN);
        stall = 1'b0;

        // Start held for 40 edges yields exactly one run
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        e = cyc;
        push_run(e, 0, DIM, 1);
        $display("start storm at cyc %0d", e);
        repeat (39) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        finish_run("storm", FLEN);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("storm_quiet", busy, 0);

        do_start(e);
        push_run(e, 0, DIM, 1);
        $display("start after_storm at cyc %0d", e);
        finish_run("after_storm", FLEN);

        // Reset during DRAIN at row 4 abandons the run
        do_start(e);
        push_run(e, 0, 5, 0);
        $display("start rst_drain at cyc %0d", e);
        repeat (DIM + FLEN + 4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_drain");
        repeat (LAT) @(posedge clk);
        #1;
        finish_run("rst_drain", FLEN);

        // Start coincident with reset is ignored
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_start_busy2", busy, 0);

        do_start(e);
        push_run(e, 0, DIM, 1);
        $display("start after_rst at cyc %0d", e);
        finish_run("after_rst", FLEN);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
